// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, default bit timing and
// 8N1 frame constants used by both the transmitter and the receiver.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START_BIT = 3'd1,
      DATA_BITS = 3'd2,
      STOP_BIT  = 3'd3,
      CLEANUP   = 3'd4,
      WAIT_IDLE = 3'd5
   } uart_state_e;

   localparam int   UART_CLKS_PER_BIT_DEFAULT = 27;
   localparam int   UART_DATA_BITS            = 8;
   localparam logic UART_START_LEVEL          = 1'b0;
   localparam logic UART_STOP_LEVEL           = 1'b1;
   localparam logic UART_IDLE_LEVEL           = 1'b1;

   // Terminal count for the start-bit check: lands near the start-bit centre.
   function automatic logic [7:0] uart_half_bit(input int clks_per_bit);
      return 8'((clks_per_bit - 1) / 2);
   endfunction

   // Terminal count for one full bit period.
   function automatic logic [7:0] uart_bit_last(input int clks_per_bit);
      return 8'(clks_per_bit - 1);
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit.
module sync_2ff #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic i_Clock,
   input  logic i_Reset,
   input  logic i_d,
   output logic o_q
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;

   // Shift the asynchronous input through two stages.
   always_comb begin
      meta_d = i_d;
      sync_d = meta_q;
   end

   // Both stages reset to RESET_VAL so reset release never looks like an edge.
   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         meta_q <= RESET_VAL;
         sync_q <= RESET_VAL;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign o_q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver. Bit timing uses a down-counter that is loaded on each
// phase entry and acts on terminal count zero.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | line idle, waiting for a low level on rx_s
// START_BIT | timing to start-bit centre; reject if line went high again
// DATA_BITS | sample 8 data bits, LSB first, at bit centres
// STOP_BIT  | sample stop bit: high -> byte valid, low -> framing error
// CLEANUP   | one cycle; clears pulses, picks IDLE or WAIT_IDLE
// WAIT_IDLE | line stuck low (break); hold until it returns high
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT
) (
   input  logic       i_Clock,
   input  logic       i_Reset,
   input  logic       i_Rx_Serial,
   output logic       o_Rx_DV,
   output logic [7:0] o_Rx_Byte,
   output logic       o_Rx_Frame_Err,
   output logic       o_Rx_Active
);

   localparam logic [7:0] HALF_CNT = uart_half_bit(CLKS_PER_BIT);
   localparam logic [7:0] BIT_CNT  = uart_bit_last(CLKS_PER_BIT);
   localparam logic [2:0] IDX_LAST = 3'(UART_DATA_BITS - 1);

   logic rx_s;

   uart_state_e               state_q, state_d;
   logic [7:0]                cnt_q, cnt_d;
   logic [2:0]                idx_q, idx_d;
   logic [UART_DATA_BITS-1:0] data_q, data_d;
   logic [7:0]                rx_byte_q, rx_byte_d;
   logic                      rx_dv_q, rx_dv_d;
   logic                      frame_err_q, frame_err_d;
   logic                      active_q, active_d;

   sync_2ff #(
      .RESET_VAL (UART_IDLE_LEVEL)
   ) u_sync (
      .i_Clock (i_Clock),
      .i_Reset (i_Reset),
      .i_d     (i_Rx_Serial),
      .o_q     (rx_s)
   );

   // Next-state and output decode; pulses default low so each lasts one cycle.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      data_d      = data_q;
      rx_byte_d   = rx_byte_q;
      rx_dv_d     = 1'b0;
      frame_err_d = 1'b0;
      active_d    = active_q;

      case (state_q)
         IDLE: begin
            cnt_d    = 8'd0;
            idx_d    = 3'd0;
            active_d = 1'b0;
            if (rx_s == UART_START_LEVEL) begin
               cnt_d   = HALF_CNT;
               state_d = START_BIT;
            end
         end

         START_BIT: begin
            if (cnt_q == 8'd0) begin
               if (rx_s == UART_START_LEVEL) begin
                  cnt_d    = BIT_CNT;
                  active_d = 1'b1;
                  state_d  = DATA_BITS;
               end else begin
                  // Too short to be a start bit: treat as a glitch.
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end

         DATA_BITS: begin
            if (cnt_q == 8'd0) begin
               data_d[idx_q] = rx_s;
               cnt_d         = BIT_CNT;
               if (idx_q == IDX_LAST) begin
                  idx_d   = 3'd0;
                  state_d = STOP_BIT;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end

         STOP_BIT: begin
            if (cnt_q == 8'd0) begin
               if (rx_s == UART_STOP_LEVEL) begin
                  rx_byte_d = data_q;
                  rx_dv_d   = 1'b1;
               end else begin
                  // Byte register keeps its last valid value on a bad frame.
                  frame_err_d = 1'b1;
               end
               state_d = CLEANUP;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end

         CLEANUP: begin
            cnt_d = 8'd0;
            if (rx_s == UART_IDLE_LEVEL) begin
               active_d = 1'b0;
               state_d  = IDLE;
            end else begin
               state_d = WAIT_IDLE;
            end
         end

         WAIT_IDLE: begin
            if (rx_s == UART_IDLE_LEVEL) begin
               active_d = 1'b0;
               state_d  = IDLE;
            end
         end

         default: begin
            cnt_d    = 8'd0;
            idx_d    = 3'd0;
            active_d = 1'b0;
            state_d  = IDLE;
         end
      endcase
   end

   // State and registered outputs; reset discards any partial frame.
   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         state_q     <= IDLE;
         cnt_q       <= 8'd0;
         idx_q       <= 3'd0;
         data_q      <= '0;
         rx_byte_q   <= 8'h00;
         rx_dv_q     <= 1'b0;
         frame_err_q <= 1'b0;
         active_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         data_q      <= data_d;
         rx_byte_q   <= rx_byte_d;
         rx_dv_q     <= rx_dv_d;
         frame_err_q <= frame_err_d;
         active_q    <= active_d;
      end
   end

   assign o_Rx_DV        = rx_dv_q;
   assign o_Rx_Byte      = rx_byte_q;
   assign o_Rx_Frame_Err = frame_err_q;
   assign o_Rx_Active    = active_q;

endmodule
